// File: rtl/sprite_animator.sv
// -----------------------------------------------------------------------------
// sprite_animator
//
// Animation and placement engine for the VGA sprite pipeline. Sits between the
// timing generator and the frame/palette lookups. Once per video frame (the
// cycle where pix_x==0 && pix_y==0) it advances a free-running frame counter, a
// speed divider and the animation frame index according to the playback mode.
// The sprite window qualifier and sprite-local coordinates are combinational
// from the pixel position so they stay pixel-aligned with the timing generator.
//
// Optional feature macro: SPRITE_BOUNCE_EN
//   defined   : the sprite box bounces one pixel per frame in X and Y, reversing
//               at the 640x480 screen edges; motion freezes in hold mode.
//   undefined : the sprite box is fixed at (X0, Y0).
//
// Ports
//   clk           in  pixel clock
//   rst_n         in  asynchronous active-low reset
//   pix_x, pix_y  in  current pixel from the timing generator (10 bits each)
//   mode          in  00 loop, 01 ping-pong, 10 one-shot, 11 hold
//   speed         in  video frames per animation step, minus 1
//   trigger       in  single-cycle pulse restarting playback
//   frame_num     out current animation frame
//   frame_counter out free-running 7-bit video-frame count
//   done          out one-shot sequence finished
//   in_sprite     out current pixel lies inside the sprite box
//   spr_x, spr_y  out sprite-local coordinates
// -----------------------------------------------------------------------------
module sprite_animator #(
  parameter int N_FRAMES = 4,
  parameter int FW       = $clog2(N_FRAMES),
  parameter int DIV_W    = 4,
  parameter int SPR_W    = 256,
  parameter int SPR_H    = 256,
  parameter int X0       = 256,
  parameter int Y0       = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               pix_x,
  input  logic [9:0]               pix_y,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         speed,
  input  logic                     trigger,
  output logic [FW-1:0]            frame_num,
  output logic [6:0]               frame_counter,
  output logic                     done,
  output logic                     in_sprite,
  output logic [$clog2(SPR_W)-1:0] spr_x,
  output logic [$clog2(SPR_H)-1:0] spr_y
);

  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);
  localparam logic [FW-1:0] LAST    = FW'(N_FRAMES - 1);
  localparam logic [FW-1:0] LAST_M1 = FW'(N_FRAMES - 2);
  localparam logic [FW-1:0] ONE     = FW'(1);

  logic [FW-1:0]    r_frame;
  logic [6:0]       r_fcnt;
  logic             r_done;
  logic             r_dir;     // 0 = counting up, 1 = counting down
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_mode_q;

  logic [FW-1:0]    w_frame_nxt;
  logic             w_done_nxt;
  logic             w_dir_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_tick;
  logic             w_mode_chg;
  logic [9:0]       w_pos_x;
  logic [9:0]       w_pos_y;
  logic [9:0]       w_dx;
  logic [9:0]       w_dy;

  assign w_tick     = (pix_x == 10'd0) && (pix_y == 10'd0);
  assign w_mode_chg = (mode != r_mode_q);

  // Next-state for the animation controls. Order of precedence: a mode change
  // clears done/dir, then trigger overrides everything, otherwise a tick may
  // advance the divider and, on divider match, take one animation step.
  always_comb begin
    w_frame_nxt = r_frame;
    w_done_nxt  = r_done;
    w_dir_nxt   = r_dir;
    w_div_nxt   = r_div;
    if (w_mode_chg) begin
      w_done_nxt = 1'b0;
      w_dir_nxt  = 1'b0;
    end
    if (trigger) begin
      w_frame_nxt = '0;
      w_div_nxt   = '0;
      w_dir_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end else if (w_tick) begin
      if (r_div == speed) begin
        w_div_nxt = '0;
        case (mode)
          2'b00: begin
            w_frame_nxt = (r_frame == LAST) ? '0 : r_frame + 1'b1;
          end
          2'b01: begin
            // Turn around on reaching an end so each end frame shows once.
            // Entering ping-pong while already at an end is handled by
            // stepping away from it.
            if (!w_dir_nxt) begin
              if (r_frame == LAST) begin
                w_frame_nxt = LAST_M1;
                w_dir_nxt   = 1'b1;
              end else begin
                w_frame_nxt = r_frame + 1'b1;
                if (r_frame == LAST_M1) w_dir_nxt = 1'b1;
              end
            end else begin
              if (r_frame == '0) begin
                w_frame_nxt = ONE;
                w_dir_nxt   = 1'b0;
              end else begin
                w_frame_nxt = r_frame - 1'b1;
                if (r_frame == ONE) w_dir_nxt = 1'b0;
              end
            end
          end
          2'b10: begin
            if (r_frame == LAST) begin
              w_done_nxt = 1'b1;
            end else begin
              w_frame_nxt = r_frame + 1'b1;
              if (r_frame == LAST_M1) w_done_nxt = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end else begin
        // Free wrap through 2^DIV_W when speed was lowered below div_cnt.
        w_div_nxt = r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= '0;
      r_fcnt   <= '0;
      r_done   <= 1'b0;
      r_dir    <= 1'b0;
      r_div    <= '0;
      r_mode_q <= 2'b00;
    end else begin
      r_frame  <= w_frame_nxt;
      r_done   <= w_done_nxt;
      r_dir    <= w_dir_nxt;
      r_div    <= w_div_nxt;
      r_mode_q <= mode;
      if (w_tick) r_fcnt <= r_fcnt + 7'd1;
    end
  end

`ifdef SPRITE_BOUNCE_EN
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  logic       r_xneg;  // 1 = moving -X
  logic       r_yneg;  // 1 = moving -Y
  logic       w_x_hit_hi;
  logic       w_y_hit_hi;

  // True when a +1 step would push the far edge of the box past the screen.
  assign w_x_hit_hi = (12'(r_pos_x) + 12'(SPR_W) + 12'd1) > 12'd640;
  assign w_y_hit_hi = (12'(r_pos_y) + 12'(SPR_H) + 12'd1) > 12'd480;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x <= 10'(X0);
      r_pos_y <= 10'(Y0);
      r_xneg  <= 1'b0;
      r_yneg  <= 1'b0;
    end else if (w_tick && (mode != 2'b11)) begin
      // On a reversal the box moves in the new direction on the same tick.
      if (!r_xneg) begin
        if (w_x_hit_hi) begin
          r_xneg  <= 1'b1;
          r_pos_x <= r_pos_x - 10'd1;
        end else begin
          r_pos_x <= r_pos_x + 10'd1;
        end
      end else begin
        if (r_pos_x == 10'd0) begin
          r_xneg  <= 1'b0;
          r_pos_x <= r_pos_x + 10'd1;
        end else begin
          r_pos_x <= r_pos_x - 10'd1;
        end
      end
      if (!r_yneg) begin
        if (w_y_hit_hi) begin
          r_yneg  <= 1'b1;
          r_pos_y <= r_pos_y - 10'd1;
        end else begin
          r_pos_y <= r_pos_y + 10'd1;
        end
      end else begin
        if (r_pos_y == 10'd0) begin
          r_yneg  <= 1'b0;
          r_pos_y <= r_pos_y + 10'd1;
        end else begin
          r_pos_y <= r_pos_y - 10'd1;
        end
      end
    end
  end

  assign w_pos_x = r_pos_x;
  assign w_pos_y = r_pos_y;
`else
  assign w_pos_x = 10'(X0);
  assign w_pos_y = 10'(Y0);
`endif

  // Unsigned wrap makes pixels left of / above the box look huge, so a single
  // less-than test per axis bounds the box on both sides.
  assign w_dx = pix_x - w_pos_x;
  assign w_dy = pix_y - w_pos_y;

  assign in_sprite     = (11'(w_dx) < 11'(SPR_W)) && (11'(w_dy) < 11'(SPR_H));
  assign spr_x         = w_dx[SXW-1:0];
  assign spr_y         = w_dy[SYW-1:0];
  assign frame_num     = r_frame;
  assign frame_counter = r_fcnt;
  assign done          = r_done;

endmodule
